// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT datapath front end and output side.
package fft_pkg;

  localparam int FFT_WORD_WIDTH = 16;
  localparam int FFT_NWORDS     = 4;

  // Output sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_t;

  // Input-side controller states.
  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_LOAD  = 2'd1,
    CTRL_START = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous push-button.
// The detector arms only once the button has been seen released after reset.
module button_sync (
  input  logic Clock,
  input  logic nReset,
  input  logic ButtonIn,
  output logic Pulse
);

  logic sync1, sync2, prev;
  logic primed, armed;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // which is what makes sync1 -> sync2 a true two-stage chain.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync1  <= ButtonIn;
      sync2  <= sync1;
      prev   <= sync2;
      primed <= 1'b1;
      // sync1 only reflects the real button once primed; a button held through
      // reset keeps sync1 high, so the detector stays disarmed until release.
      if (primed && !sync1 && !sync2)
        armed <= 1'b1;
    end
  end

  assign Pulse = armed & sync2 & ~prev;

endmodule

// File: rtl/fft_output_sequencer.sv
// Holds one butterfly result and steps through its words on each button press.
module fft_output_sequencer
  import fft_pkg::*;
#(
  parameter int WIDTH  = FFT_WORD_WIDTH,
  parameter int NWORDS = FFT_NWORDS
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      ResultValid,
  input  logic [NWORDS*WIDTH-1:0]   ResultIn,
  input  logic                      ReadyOut,
  output logic [WIDTH-1:0]          dataOut,
  output logic [$clog2(NWORDS)-1:0] WordIndex,
  output logic                      Busy,
  output logic                      Finished,
  output logic                      Overrun
);

  localparam int IDXW = $clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
  localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

  logic             ack;
  seq_state_t       state;
  logic [WIDTH-1:0] buffer [NWORDS];
  logic [IDXW-1:0]  next_idx;

  button_sync u_button_sync (
    .Clock    (Clock),
    .nReset   (nReset),
    .ButtonIn (ReadyOut),
    .Pulse    (ack)
  );

  assign next_idx = WordIndex + ONE_IDX;

  // NOTE: the buffer is a plain register array, so clearing it on reset is
  // cheap and guarantees no stale result survives a mid-readout reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      dataOut   <= '0;
      WordIndex <= '0;
      Busy      <= 1'b0;
      Finished  <= 1'b0;
      Overrun   <= 1'b0;
      for (int i = 0; i < NWORDS; i++)
        buffer[i] <= '0;
    end else begin
      if (ResultValid && state != ST_IDLE)
        Overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          // A capture wins over a coincident ack; that ack is simply dropped.
          if (ResultValid) begin
            for (int i = 0; i < NWORDS; i++)
              buffer[i] <= ResultIn[i*WIDTH +: WIDTH];
            dataOut   <= ResultIn[WIDTH-1:0];
            WordIndex <= '0;
            Busy      <= 1'b1;
            state     <= ST_SHOW;
          end
        end

        ST_SHOW: begin
          if (ack) begin
            if (WordIndex == LAST_IDX) begin
              Busy     <= 1'b0;
              Finished <= 1'b1;
              state    <= ST_FINISH;
            end else begin
              WordIndex <= next_idx;
              dataOut   <= buffer[next_idx];
            end
          end
        end

        ST_FINISH: begin
          if (ack) begin
            Finished  <= 1'b0;
            WordIndex <= '0;
            dataOut   <= '0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          Busy     <= 1'b0;
          Finished <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_output_sequencer.sv
// Directed bench for fft_output_sequencer: readout, long press, overrun,
// simultaneous events, mid-readout reset and asynchronous button timing.
`timescale 1ns/1ps
module tb_fft_output_sequencer;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        ResultValid = 1'b0;
  logic [63:0] ResultIn = '0;
  logic        ReadyOut = 1'b0;
  logic [15:0] dataOut;
  logic [1:0]  WordIndex;
  logic        Busy, Finished, Overrun;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] WORDS = {16'h8000, 16'h7FFF, 16'hFFFB, 16'h0005};

  // {Busy, Finished, Overrun, WordIndex, dataOut}
  logic [20:0] obs;
  assign obs = {Busy, Finished, Overrun, WordIndex, dataOut};

  fft_output_sequencer dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .ResultValid (ResultValid),
    .ResultIn    (ResultIn),
    .ReadyOut    (ReadyOut),
    .dataOut     (dataOut),
    .WordIndex   (WordIndex),
    .Busy        (Busy),
    .Finished    (Finished),
    .Overrun     (Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic apply_reset();
    @(negedge Clock);
    #2 nReset = 1'b0;
    #10;
    @(negedge Clock);
    nReset = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic load(input logic [63:0] words);
    @(negedge Clock);
    ResultIn    = words;
    ResultValid = 1'b1;
    @(negedge Clock);
    ResultValid = 1'b0;
  endtask

  task automatic press(input int hold);
    @(negedge Clock);
    ReadyOut = 1'b1;
    repeat (hold) @(negedge Clock);
    ReadyOut = 1'b0;
    repeat (5) @(negedge Clock);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    #12;
    n_checks++;
    if (obs !== 21'h0) begin
      $display("FAIL reset_state: got %h expected %h", obs, 21'h0);
      n_fail++;
    end
    @(negedge Clock);
    nReset = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic test_normal_readout();
    logic [20:0] exp_seq [6];
    exp_seq[0] = {1'b1, 1'b0, 1'b0, 2'd0, 16'h0005};
    exp_seq[1] = {1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFB};
    exp_seq[2] = {1'b1, 1'b0, 1'b0, 2'd2, 16'h7FFF};
    exp_seq[3] = {1'b1, 1'b0, 1'b0, 2'd3, 16'h8000};
    exp_seq[4] = {1'b0, 1'b1, 1'b0, 2'd3, 16'h8000};
    exp_seq[5] = {1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
    load(WORDS);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) press(2);
      n_checks++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL readout_step%0d: got %h expected %h", i, obs, exp_seq[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_signed_word();
    apply_reset();
    load(WORDS);
    press(2);
    n_checks++;
    if ($signed(dataOut) !== -16'sd5) begin
      $display("FAIL signed_word: got %0d expected -5", $signed(dataOut));
      n_fail++;
    end
  endtask

  task automatic test_long_press();
    apply_reset();
    load(WORDS);
    press(50);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFB}) begin
      $display("FAIL long_press: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFB});
      n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    // Button edge at N0; the ack is seen by the FSM on the third rising edge.
    @(negedge Clock);
    ReadyOut = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    ResultIn    = WORDS;
    ResultValid = 1'b1;
    @(negedge Clock);
    ResultValid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'd0, 16'h0005}) begin
      $display("FAIL simultaneous_capture: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 2'd0, 16'h0005});
      n_fail++;
    end
    repeat (6) @(negedge Clock);
    ReadyOut = 1'b0;
    repeat (4) @(negedge Clock);
    n_checks++;
    if (WordIndex !== 2'd0) begin
      $display("FAIL simultaneous_no_skip: got %0d expected 0", WordIndex);
      n_fail++;
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    load(WORDS);
    press(2);
    press(2);
    load({4{16'h1111}});
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 2'd2, 16'h7FFF}) begin
      $display("FAIL overrun_set: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b1, 2'd2, 16'h7FFF});
      n_fail++;
    end
    press(2);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 2'd3, 16'h8000}) begin
      $display("FAIL overrun_buffer_kept: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b1, 2'd3, 16'h8000});
      n_fail++;
    end
    press(2);
    n_checks++;
    if (obs !== {1'b0, 1'b1, 1'b1, 2'd3, 16'h8000}) begin
      $display("FAIL overrun_finish: got %h expected %h", obs,
               {1'b0, 1'b1, 1'b1, 2'd3, 16'h8000});
      n_fail++;
    end
    press(2);
    n_checks++;
    if (obs !== {1'b0, 1'b0, 1'b1, 2'd0, 16'h0000}) begin
      $display("FAIL overrun_idle: got %h expected %h", obs,
               {1'b0, 1'b0, 1'b1, 2'd0, 16'h0000});
      n_fail++;
    end
    apply_reset();
    n_checks++;
    if (Overrun !== 1'b0) begin
      $display("FAIL overrun_reset_clear: got %b expected 0", Overrun);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load(WORDS);
    press(2);
    @(negedge Clock);
    ReadyOut = 1'b1;
    repeat (3) @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 21'h0) begin
      $display("FAIL reset_mid_outputs: got %h expected %h", obs, 21'h0);
      n_fail++;
    end
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    repeat (6) @(negedge Clock);
    load(WORDS);
    repeat (10) @(negedge Clock);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'd0, 16'h0005}) begin
      $display("FAIL reset_mid_held_no_ack: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 2'd0, 16'h0005});
      n_fail++;
    end
    ReadyOut = 1'b0;
    repeat (6) @(negedge Clock);
    n_checks++;
    if (WordIndex !== 2'd0) begin
      $display("FAIL reset_mid_release_no_ack: got %0d expected 0", WordIndex);
      n_fail++;
    end
    press(2);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFB}) begin
      $display("FAIL reset_mid_fresh_press: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFB});
      n_fail++;
    end
  endtask

  task automatic test_jitter();
    int offs [3] = '{1, 4, 7};
    logic [1:0] start;
    int lat;
    apply_reset();
    load(WORDS);
    for (int i = 0; i < 3; i++) begin
      start = WordIndex;
      @(posedge Clock);
      #(offs[i]);
      ReadyOut = 1'b1;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge Clock);
        #1;
        if (lat == 0 && WordIndex !== start) lat = k;
      end
      n_checks++;
      if (lat != 3) begin
        $display("FAIL jitter_latency%0d: got %0d cycles expected 3", i, lat);
        n_fail++;
      end
      n_checks++;
      if (WordIndex !== start + 2'd1) begin
        $display("FAIL jitter_single_ack%0d: got %0d expected %0d", i, WordIndex,
                 start + 2'd1);
        n_fail++;
      end
      @(posedge Clock);
      #(offs[i]);
      ReadyOut = 1'b0;
      repeat (4) @(posedge Clock);
    end
    // A glitch that never straddles a rising edge is never sampled.
    @(posedge Clock);
    #2 ReadyOut = 1'b1;
    #3 ReadyOut = 1'b0;
    repeat (6) @(posedge Clock);
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'd3, 16'h8000}) begin
      $display("FAIL jitter_glitch: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 2'd3, 16'h8000});
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_normal_readout();
    test_signed_word();
    test_long_press();
    test_simultaneous();
    test_overrun();
    test_reset_mid();
    test_jitter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_output_sequencer.md
FFT_OUTPUT_SEQUENCER -- requirements
Module: fft_output_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, bit width of one signed result word.
REQ-002 Parameter NWORDS, default 4, number of result words per butterfly (A.re, A.im, B.re, B.im); must be a power of two, at least 2.
REQ-003 Clock  input  1  single clock; all state on rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 ResultValid  input  1  one-cycle strobe from the datapath: ResultIn holds a complete butterfly result.
REQ-006 ResultIn  input  NWORDS*WIDTH  packed signed results, word 0 in the LSBs.
REQ-007 ReadyOut  input  1  raw push-button from the board, asynchronous to Clock, active-high.
REQ-008 dataOut  output  WIDTH  signed word currently presented, registered.
REQ-009 WordIndex  output  log2(NWORDS)  index of the word on dataOut.
REQ-010 Busy  output  1  high while a result is held and not yet fully read out.
REQ-011 Finished  output  1  high after the last word has been acknowledged.
REQ-012 Overrun  output  1  sticky; set when ResultValid arrives while Busy.

Function
REQ-013 ReadyOut shall pass through a two-flop synchronizer, then a rising-edge detector; one press yields exactly one single-cycle Ack, however long it is held.
REQ-014 FSM states: IDLE, SHOW, FINISH.
REQ-015 IDLE: on ResultValid, capture ResultIn into an internal NWORDS x WIDTH buffer, set index to 0, go to SHOW next cycle.
REQ-016 SHOW: dataOut equals buffer[index]; on Ack with index < NWORDS-1, increment index and stay in SHOW.
REQ-017 SHOW: on Ack with index = NWORDS-1, go to FINISH; index stays NWORDS-1.
REQ-018 FINISH: Finished = 1, dataOut holds the last word; on Ack go to IDLE, index cleared to 0.
REQ-019 IDLE: on ResultValid and Ack in the same cycle, capture takes priority; the Ack is discarded.
REQ-020 SHOW or FINISH: ResultValid shall not alter the buffer or index, and shall set Overrun.
REQ-021 Overrun clears only on reset.
REQ-022 Busy = 1 exactly in SHOW; Finished = 1 exactly in FINISH.
REQ-023 dataOut and WordIndex update in the cycle after the triggering capture or Ack, a latency of 1 clock.
REQ-024 In IDLE, dataOut shall be 0.
REQ-025 Words are passed unmodified, sign preserved, with no arithmetic on them.

Reset
REQ-026 Asserting nReset at any time, including mid-readout, shall force IDLE, clear the buffer, dataOut = 0, WordIndex = 0, Busy = 0, Finished = 0, Overrun = 0 and both synchronizer flops to 0.
REQ-027 After deassertion, a button already held shall produce no Ack until it is released and pressed again.

Structure
REQ-028 The state enum type and the constants FFT_WORD_WIDTH = 16 and FFT_NWORDS = 4 shall live in the shared package fft_pkg, alongside the controller state type.
REQ-029 The synchronizer and edge detector shall be one sub-module, button_sync (ports Clock, nReset, ButtonIn, Pulse), reusable by the input-side controller.
REQ-030 The buffer shall be a register array; no RAM inference.

Verification
REQ-031 Normal readout: apply ResultIn words {0x0005, 0xFFFB, 0x7FFF, 0x8000} and pulse ResultValid, then press 4 times -> dataOut shows 5, -5, 32767, -32768 in that order; FINISH after the 4th press; 5th press -> IDLE.
REQ-032 Long press: hold ReadyOut for 50 cycles while in SHOW with index 0 -> exactly one increment, WordIndex = 1.
REQ-033 Overrun: pulse ResultValid at index 2 with new data 0x1111 -> buffer unchanged, Overrun = 1 and stays set through FINISH and IDLE.
REQ-034 Simultaneous events: ResultValid and Ack in the same cycle in IDLE -> SHOW with WordIndex = 0; no skip.
REQ-035 Reset mid-operation: assert nReset at index 1 while the button is held -> all outputs 0 immediately; no Ack after release until a fresh press.
REQ-036 Metastability path: toggle ReadyOut asynchronously (jittered edges) -> Ack appears 2 to 3 cycles after a rising edge, never twice per press.
